window_avg_sched: RTL and testbench

WINDOW_AVG_SCHED -- requirements
Module: window_avg_sched

---
 rtl/window_avg_sched.sv | 151 +++++++++++++++
 tb/tb_window_avg_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_avg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_avg_sched: round-robin scheduler sharing one ap_ctrl_chain kernel |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module window_avg_sched #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NREQ-1:0]              req,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              done,
  output logic                         k_ap_start,
  input  logic                         k_ap_ready,
  input  logic                         k_ap_done,
  output logic                         k_ap_continue,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         busy,
  output logic                         timeout_err,
  output logic                         proto_err,
  input  logic                         err_clr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   cur_id_q, cur_id_d;
  logic [IW-1:0]   fifo_q [MAX_OUT];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            timeout_err_q, proto_err_q;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IW-1:0]     win_off;
  logic [IW:0]       win_sum;
  logic [IW-1:0]     win_id;
  logic              win_vld;
  logic              accept, pop, timeout_set, proto_set;

  // Rotate requests so that bit 0 is the requester at the round-robin pointer.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[rr_q +: NREQ];
    win_vld = |req;
    win_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) win_off = IW'(i);
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off};
    win_id  = (win_sum >= (IW+1)'(NREQ)) ? IW'(win_sum - (IW+1)'(NREQ)) : IW'(win_sum);
  end

  assign accept      = (state_q == S_ISSUE) && k_ap_ready;
  assign pop         = k_ap_done && (cnt_q != '0);
  assign proto_set   = k_ap_done && (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    rr_d     = rr_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld && (cnt_q < OW'(MAX_OUT))) begin
          state_d  = S_ISSUE;
          cur_id_d = win_id;
        end
      end
      S_ISSUE: begin
        if (k_ap_ready) begin
          state_d = S_IDLE;
          rr_d    = (cur_id_q == IW'(NREQ - 1)) ? '0 : cur_id_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + OW'(1);
    else if (!accept && pop) cnt_d = cnt_q - OW'(1);

    gnt_d  = accept ? (NREQ'(1) << cur_id_q) : '0;
    done_d = pop ? (NREQ'(1) << fifo_q[rd_ptr_q]) : '0;

    // Watchdog only runs while work is in flight and nothing has completed.
    if (pop || (cnt_q == '0))       wd_d = '0;
    else if (wd_q == WW'(TIMEOUT))  wd_d = wd_q;
    else                            wd_d = wd_q + WW'(1);
    timeout_set = (wd_q != WW'(TIMEOUT)) && (wd_d == WW'(TIMEOUT));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      cur_id_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      wd_q          <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      if (accept) wr_ptr_q <= (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + PW'(1);
      // A set event in the same cycle as err_clr wins.
      timeout_err_q <= timeout_set | (timeout_err_q & ~err_clr);
      proto_err_q   <= proto_set | (proto_err_q & ~err_clr);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (accept) fifo_q[wr_ptr_q] <= cur_id_q;
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign k_ap_start    = (state_q == S_ISSUE);
  assign k_ap_continue = (cnt_q != '0);
  assign outstanding   = cnt_q;
  assign busy          = (state_q == S_ISSUE) || (cnt_q != '0);
  assign timeout_err   = timeout_err_q;
  assign proto_err     = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_window_avg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_window_avg_sched: directed self-checking bench for window_avg_sched   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_window_avg_sched;

  logic       ap_clk;
  logic       ap_rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       k_ap_start;
  logic       k_ap_ready;
  logic       k_ap_done;
  logic       k_ap_continue;
  logic [1:0] outstanding;
  logic       busy;
  logic       timeout_err;
  logic       proto_err;
  logic       err_clr;

  int n_chk  = 0;
  int n_pass = 0;

  window_avg_sched #(
    .NREQ   (4),
    .MAX_OUT(2),
    .TIMEOUT(16)
  ) u_dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .req          (req),
    .gnt          (gnt),
    .done         (done),
    .k_ap_start   (k_ap_start),
    .k_ap_ready   (k_ap_ready),
    .k_ap_done    (k_ap_done),
    .k_ap_continue(k_ap_continue),
    .outstanding  (outstanding),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .proto_err    (proto_err),
    .err_clr      (err_clr)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic apply_reset();
    ap_rst_n   = 1'b0;
    req        = '0;
    k_ap_ready = 1'b0;
    k_ap_done  = 1'b0;
    err_clr    = 1'b0;
    repeat (2) step();
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ap_rst_n   = 1'b0;
    req        = 4'b1111;
    k_ap_ready = 1'b1;
    k_ap_done  = 1'b1;
    err_clr    = 1'b0;
    repeat (3) step();
    n_chk++;
    if ({gnt, done, k_ap_start, k_ap_continue, outstanding, busy, timeout_err, proto_err} !== 15'd0)
      $display("FAIL reset_outputs: got gnt=%b done=%b start=%b cont=%b out=%0d busy=%b terr=%b perr=%b, want all 0",
               gnt, done, k_ap_start, k_ap_continue, outstanding, busy, timeout_err, proto_err);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single();
    bit done_early = 0;
    req = 4'b0001;
    step();
    n_chk++; if (k_ap_start !== 1'b1) $display("FAIL single_start: got %b want 1", k_ap_start); else n_pass++;
    step();
    k_ap_ready = 1'b1;
    step();
    n_chk++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    n_chk++; if (outstanding !== 2'd1) $display("FAIL single_out1: got %0d want 1", outstanding); else n_pass++;
    n_chk++; if (k_ap_continue !== 1'b1) $display("FAIL single_cont: got %b want 1", k_ap_continue); else n_pass++;
    req = '0;
    k_ap_ready = 1'b0;
    step();
    n_chk++; if (gnt !== 4'b0000) $display("FAIL single_gnt_pulse: got %b want 0000", gnt); else n_pass++;
    repeat (141) begin
      step();
      if (done !== 4'b0000) done_early = 1;
    end
    n_chk++; if (done_early) $display("FAIL single_no_early_done: got 1 want 0"); else n_pass++;
    k_ap_done = 1'b1;
    step();
    k_ap_done = 1'b0;
    n_chk++; if (done !== 4'b0001) $display("FAIL single_done: got %b want 0001", done); else n_pass++;
    n_chk++; if (outstanding !== 2'd0) $display("FAIL single_out0: got %0d want 0", outstanding); else n_pass++;
    step();
    n_chk++; if (done !== 4'b0000) $display("FAIL single_done_pulse: got %b want 0000", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] got_g [5];
    int ng = 0;
    bit over = 0, start_full = 0;
    apply_reset();
    req = 4'b1111;
    k_ap_ready = 1'b1;
    for (int c = 0; c < 80 && ng < 5; c++) begin
      step();
      if (gnt !== 4'b0000) begin got_g[ng] = gnt; ng++; end
      if (outstanding > 2'd2) over = 1;
      if (outstanding == 2'd2 && k_ap_start) start_full = 1;
      k_ap_done = (outstanding == 2'd2);
    end
    n_chk++; if (ng != 5) $display("FAIL rr_grant_count: got %0d want 5", ng); else n_pass++;
    for (int k = 0; k < ng; k++) begin
      n_chk++;
      if (got_g[k] !== exp_g[k]) $display("FAIL rr_order[%0d]: got %b want %b", k, got_g[k], exp_g[k]);
      else n_pass++;
    end
    n_chk++; if (over) $display("FAIL rr_max_out: got >2 want <=2"); else n_pass++;
    n_chk++; if (start_full) $display("FAIL rr_start_when_full: got 1 want 0"); else n_pass++;
    req = '0;
    k_ap_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      k_ap_done = (outstanding != 2'd0);
      step();
    end
    k_ap_done = 1'b0;
    n_chk++; if (outstanding !== 2'd0) $display("FAIL rr_drain: got %0d want 0", outstanding); else n_pass++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req = 4'b0001;
    k_ap_ready = 1'b1;
    repeat (2) step();
    req = 4'b0100;
    k_ap_ready = 1'b0;
    step();
    n_chk++; if (k_ap_start !== 1'b1) $display("FAIL simul_start: got %b want 1", k_ap_start); else n_pass++;
    k_ap_ready = 1'b1;
    k_ap_done  = 1'b1;
    step();
    n_chk++; if (outstanding !== 2'd1) $display("FAIL simul_out: got %0d want 1", outstanding); else n_pass++;
    n_chk++; if (done !== 4'b0001) $display("FAIL simul_done: got %b want 0001", done); else n_pass++;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL simul_gnt: got %b want 0100", gnt); else n_pass++;
    k_ap_ready = 1'b0;
    k_ap_done  = 1'b0;
    req = '0;
    step();
    k_ap_done = 1'b1;
    step();
    k_ap_done = 1'b0;
    n_chk++; if (done !== 4'b0100) $display("FAIL simul_head: got %b want 0100", done); else n_pass++;
    n_chk++; if (outstanding !== 2'd0) $display("FAIL simul_out0: got %0d want 0", outstanding); else n_pass++;
  endtask

  task automatic test_proto();
    apply_reset();
    k_ap_done = 1'b1;
    step();
    k_ap_done = 1'b0;
    n_chk++; if (done !== 4'b0000) $display("FAIL proto_no_done: got %b want 0000", done); else n_pass++;
    n_chk++; if (proto_err !== 1'b1) $display("FAIL proto_set: got %b want 1", proto_err); else n_pass++;
    repeat (2) step();
    n_chk++; if (proto_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", proto_err); else n_pass++;
    err_clr   = 1'b1;
    k_ap_done = 1'b1;
    step();
    n_chk++; if (proto_err !== 1'b1) $display("FAIL proto_set_priority: got %b want 1", proto_err); else n_pass++;
    k_ap_done = 1'b0;
    step();
    err_clr = 1'b0;
    n_chk++; if (proto_err !== 1'b0) $display("FAIL proto_clear: got %b want 0", proto_err); else n_pass++;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL proto_terr: got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0001;
    k_ap_ready = 1'b1;
    step();
    req = '0;
    step();
    k_ap_ready = 1'b0;
    n_chk++; if (gnt !== 4'b0001) $display("FAIL timeout_gnt_despite_drop: got %b want 0001", gnt); else n_pass++;
    repeat (15) step();
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL timeout_early: got %b want 0", timeout_err); else n_pass++;
    step();
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL timeout_at_16: got %b want 1", timeout_err); else n_pass++;
    repeat (5) step();
    k_ap_done = 1'b1;
    step();
    k_ap_done = 1'b0;
    n_chk++; if (done !== 4'b0001) $display("FAIL timeout_late_done: got %b want 0001", done); else n_pass++;
    n_chk++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++; if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b want 0", timeout_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit spurious = 0;
    apply_reset();
    req = 4'b0001;
    k_ap_ready = 1'b1;
    repeat (2) step();
    req = 4'b0010;
    k_ap_ready = 1'b0;
    step();
    n_chk++;
    if (k_ap_start !== 1'b1 || outstanding !== 2'd1)
      $display("FAIL rstmid_setup: got start=%b out=%0d want start=1 out=1", k_ap_start, outstanding);
    else n_pass++;
    ap_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({gnt, done, k_ap_start, k_ap_continue, outstanding, busy, timeout_err, proto_err} !== 15'd0)
      $display("FAIL rstmid_async: got start=%b cont=%b out=%0d busy=%b gnt=%b done=%b, want all 0",
               k_ap_start, k_ap_continue, outstanding, busy, gnt, done);
    else n_pass++;
    step();
    ap_rst_n   = 1'b1;
    req        = 4'b0011;
    k_ap_ready = 1'b1;
    step();
    if (done !== 4'b0000) spurious = 1;
    step();
    if (done !== 4'b0000) spurious = 1;
    n_chk++; if (gnt !== 4'b0001) $display("FAIL rstmid_rr0: got %b want 0001", gnt); else n_pass++;
    req = '0;
    k_ap_ready = 1'b0;
    repeat (3) begin
      step();
      if (done !== 4'b0000) spurious = 1;
    end
    n_chk++; if (spurious) $display("FAIL rstmid_spurious_done: got 1 want 0"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_simultaneous();
    test_proto();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
